// File: rtl/redirect_target_unit.sv
// redirect_target_unit: selects and aligns control-transfer targets, then holds the redirect
// under a valid/ready handshake with fetch followed by a counted front-end flush.
module redirect_target_unit #(
  parameter int XLEN         = 32,
  parameter int C_EXT        = 0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_add_in,
  input  logic [XLEN-1:0] jump_add_in,
  input  logic [XLEN-1:0] jalr_add_in,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target,
  output logic            flush,
  output logic            ex_stall,
  output logic            misaligned_exc,
  output logic [XLEN-1:0] misaligned_addr
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d, maddr_q, maddr_d, tgt;
  logic [3:0]      cnt_q, cnt_d;
  logic            exc_q, exc_d, is_br, is_jal, is_jalr, req, mis;
  assign is_br   = ex_opcode == OP_BRANCH;
  assign is_jal  = ex_opcode == OP_JAL;
  assign is_jalr = ex_opcode == OP_JALR;
  assign tgt     = is_jalr ? {jalr_add_in[XLEN-1:1], 1'b0} : is_jal ? jump_add_in : branch_add_in;
  assign mis     = (C_EXT != 0) ? tgt[0] : |tgt[1:0];
  assign req     = ex_valid && state_q == IDLE && (is_jal || is_jalr || (is_br && branch_taken));
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    maddr_d  = maddr_q;
    cnt_d    = cnt_q;
    exc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && mis) begin
          exc_d   = 1'b1;
          maddr_d = tgt;
        end else if (req) begin
          state_d  = PENDING;
          target_d = tgt;
        end
      end
      PENDING: begin
        if (redirect_ready) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        state_d = (cnt_q == 4'd0) ? IDLE : FLUSH;
        cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      maddr_q  <= '0;
      cnt_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      maddr_q  <= maddr_d;
      cnt_q    <= cnt_d;
      exc_q    <= exc_d;
    end
  end
  assign redirect_valid  = state_q == PENDING;
  assign redirect_target = target_q;
  assign flush           = state_q != IDLE;
  assign ex_stall        = state_q != IDLE;
  assign misaligned_exc  = exc_q;
  assign misaligned_addr = maddr_q;
endmodule

// File: tb/tb_redirect_target_unit.sv
// tb_redirect_target_unit: two DUT variants (C_EXT=0/FLUSH_CYCLES=2, C_EXT=1/FLUSH_CYCLES=3)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_redirect_target_unit;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, RT = 7'b0110011;
  localparam int CE [2] = '{0, 1};
  localparam int FC [2] = '{2, 3};
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, branch_taken = 0, redirect_ready = 0;
  logic [6:0] ex_opcode = 0;
  logic [31:0] b_in = 0, j_in = 0, jr_in = 0;
  logic rv [2], fl [2], st [2], ex [2];
  logic [31:0] rt [2], ma [2];
  int checks = 0, errors = 0;
  logic m_pend [2] = '{0, 0};
  logic m_exc [2] = '{0, 0};
  logic [31:0] m_tgt [2] = '{0, 0};
  logic [31:0] m_ma [2] = '{0, 0};
  int m_fl [2] = '{0, 0};

  always #5 clk = ~clk;

  redirect_target_unit #(.XLEN(32), .C_EXT(0), .FLUSH_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .branch_taken(branch_taken), .branch_add_in(b_in), .jump_add_in(j_in),
    .jalr_add_in(jr_in), .redirect_ready(redirect_ready), .redirect_valid(rv[0]),
    .redirect_target(rt[0]), .flush(fl[0]), .ex_stall(st[0]),
    .misaligned_exc(ex[0]), .misaligned_addr(ma[0]));
  redirect_target_unit #(.XLEN(32), .C_EXT(1), .FLUSH_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .branch_taken(branch_taken), .branch_add_in(b_in), .jump_add_in(j_in),
    .jalr_add_in(jr_in), .redirect_ready(redirect_ready), .redirect_valid(rv[1]),
    .redirect_target(rt[1]), .flush(fl[1]), .ex_stall(st[1]),
    .misaligned_exc(ex[1]), .misaligned_addr(ma[1]));

  // Model: a redirect is either waiting for fetch, or followed by m_fl remaining flush cycles.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 0; m_exc[i] = 0; m_tgt[i] = 0; m_ma[i] = 0; m_fl[i] = 0;
      end else begin
        logic ct;
        logic [31:0] t;
        m_exc[i] = 0;
        ct = ex_valid && (ex_opcode == JAL || ex_opcode == JALR || (ex_opcode == BR && branch_taken));
        t = (ex_opcode == JAL) ? j_in : (ex_opcode == JALR) ? (jr_in & ~32'd1) : b_in;
        if (m_pend[i]) begin
          if (redirect_ready) begin
            m_pend[i] = 0;
            m_fl[i] = FC[i];
          end
        end else if (m_fl[i] > 0) begin
          m_fl[i]--;
        end else if (ct) begin
          if ((CE[i] != 0) ? (t % 2 != 0) : (t % 4 != 0)) begin
            m_exc[i] = 1;
            m_ma[i] = t;
          end else begin
            m_pend[i] = 1;
            m_tgt[i] = t;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [67:0] got, exp;
      logic busy;
      busy = m_pend[i] || m_fl[i] > 0;
      got = {rv[i], rt[i], fl[i], st[i], ex[i], ma[i]};
      exp = {m_pend[i], m_tgt[i], busy, busy, m_exc[i], m_ma[i]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_u%0d t=%0t got %h expected %h", i, $time, got, exp);
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic tk, input logic [31:0] b,
                       input logic [31:0] j, input logic [31:0] jr, input logic rdy);
    @(posedge clk);
    #1;
    ex_valid = v; ex_opcode = op; branch_taken = tk;
    b_in = b; j_in = j; jr_in = jr; redirect_ready = rdy;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit("reset_outputs", {rv[0], fl[0], st[0], ex[0], rt[0], ma[0]}, 64'd0);
    @(posedge clk); #1 rst_n = 1;
    // taken branch, ready high: valid one cycle, flush N+1..N+3 on u0
    drive(1, BR, 1, 32'h100, 0, 0, 1);
    @(negedge clk); lit("br_n_valid", rv[0], 0);
    idle(1, 1); @(negedge clk);
    lit("br_n1_valid_tgt", {rv[0], rt[0]}, {1'b1, 32'h100});
    lit("br_n1_flush_stall", {fl[0], st[0]}, 2'b11);
    idle(1, 1); @(negedge clk);
    lit("br_n2", {rv[0], fl[0], st[0]}, 3'b011);
    idle(1, 1); @(negedge clk);
    lit("br_n3", {rv[0], fl[0], st[0]}, 3'b011);
    idle(1, 1); @(negedge clk);
    lit("br_n4_idle", {fl[0], st[0]}, 2'b00);
    lit("br_n4_u1_flush", fl[1], 1);
    idle(1, 1);
    // JALR 0x2003: u1 redirects to 0x2002, u0 traps
    drive(1, JALR, 0, 0, 0, 32'h2003, 0);
    idle(0, 1); @(negedge clk);
    lit("jalr_u1_tgt", {rv[1], ex[1], rt[1]}, {2'b10, 32'h2002});
    lit("jalr_u0_exc", {rv[0], ex[0], st[0], ma[0]}, {3'b010, 32'h2002});
    idle(0, 1); @(negedge clk);
    lit("jalr_u0_pulse_end", {ex[0], ma[0]}, {1'b0, 32'h2002});
    idle(1, 6);
    // JAL held pending for five cycles while a second JAL is offered
    drive(1, JAL, 0, 0, 32'h8000_0040, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, JAL, 0, 0, 32'h1234, 0, 0);
      @(negedge clk);
      lit("jal_hold", {rv[0], st[0], rt[0]}, {2'b11, 32'h8000_0040});
    end
    idle(1, 1); @(negedge clk);
    lit("jal_ready_cycle", rv[0], 1);
    idle(0, 1); @(negedge clk);
    lit("jal_flush_entry", {rv[0], fl[0], rt[0]}, {2'b01, 32'h8000_0040});
    idle(0, 5);
    // non-redirecting cases
    drive(1, BR, 0, 32'h100, 0, 0, 1);
    drive(1, RT, 1, 32'h100, 32'h200, 32'h300, 1);
    @(negedge clk); lit("nt_branch", {rv[0], fl[0], st[0]}, 3'b000);
    drive(0, JAL, 0, 0, 32'h200, 0, 1);
    @(negedge clk); lit("rtype", {rv[0], fl[0], st[0]}, 3'b000);
    idle(1, 1);
    @(negedge clk); lit("jal_not_valid", {rv[1], fl[1], st[1]}, 3'b000);
    // async reset in the middle of PENDING
    drive(1, JAL, 0, 0, 32'h40, 0, 0);
    idle(0, 1);
    @(negedge clk); lit("pre_reset_pending", rv[0], 1);
    #1 rst_n = 0;
    #1 lit("async_reset", {rv[0], fl[0], st[0], rv[1], fl[1], st[1], rt[0]}, 64'd0);
    @(posedge clk); #1 rst_n = 1;
    idle(1, 1);
    @(negedge clk); lit("post_reset_idle", {rv[0], st[0], rv[1], st[1]}, 4'b0000);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      case ($urandom % 5)
        0: op = BR;
        1: op = JAL;
        2: op = JALR;
        3: op = RT;
        default: op = 7'($urandom);
      endcase
      drive($urandom % 4 != 0, op, 1'($urandom), $urandom, $urandom, $urandom, $urandom % 3 == 0);
      if ($urandom % 400 == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
    end
    idle(1, 2);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
